// File: rtl/mctp_pcievdm_pkg.sv
// Shared definitions for the MCTP PCIe-VDM controller blocks.
//   arb_state_e      : state encoding of the SPI-master arbiter
//   ARB_TMO_FILL     : read data returned for beats lost to a read timeout
//   ARB_STS_*        : bit positions inside the arbiter status word
package mctp_pcievdm_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_WR_BURST = 2'd1,
    ARB_RD_CMD   = 2'd2,
    ARB_RD_WAIT  = 2'd3
  } arb_state_e;

  localparam logic [31:0] ARB_TMO_FILL = 32'hFFFF_FFFF;

  localparam int ARB_STS_RD_TMO   = 0;   // sticky: a read completion timed out
  localparam int ARB_STS_ORPHAN   = 1;   // sticky: read data arrived with no owner
  localparam int ARB_STS_TCNT_LSB = 8;   // saturating timeout count
  localparam int ARB_STS_TCNT_MSB = 15;

endpackage

// File: rtl/mctp_rr_arb2.sv
// Two-way registered round-robin arbiter.
//   clk, reset : clock, synchronous active-high reset
//   req[1:0]   : request vector
//   advance    : the owner is free, a new grant may be taken this cycle
//   gnt[1:0]   : registered one-hot grant (00 after reset)
//   gnt_nxt    : combinational pick among the current requests
// When both request, the pointer decides; after each grant the pointer moves
// to the other requester.
module mctp_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt,
  output logic [1:0] gnt_nxt
);

  logic       rr_ptr_q, rr_ptr_d;
  logic [1:0] gnt_q, gnt_d;

  always_comb begin
    gnt_nxt  = req;
    if (req == 2'b11) begin
      gnt_nxt = rr_ptr_q ? 2'b10 : 2'b01;
    end
    gnt_d    = gnt_q;
    rr_ptr_d = rr_ptr_q;
    if (advance && (req != 2'b00)) begin
      gnt_d    = gnt_nxt;
      rr_ptr_d = ~gnt_nxt[1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q    <= 2'b00;
      rr_ptr_q <= 1'b0;
    end else begin
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign gnt = gnt_q;

endmodule

// File: rtl/mctp_spi_mstr_arb.sv
// Shares one SPI-master AVMM port between the MCTP ingress master (r0) and
// the PMCI CSR/flash master (r1). Grants are round-robin and burst-atomic;
// a read whose completion stalls is finished with fill data after a timeout.
//   clk, reset, pulse_1us     : clock, sync active-high reset, 1 us strobe
//   rN_* (N=0,1)              : requester AVMM slave ports
//   s_*                       : AVMM master port to the SPI master bridge
//   sts_clr, arb_sts          : status clear, status word
//   dbg_state                 : current arbiter state (arb_state_e)
// Handshake: a command beat transfers on a cycle where write/read is high and
// waitreq is low; read data transfers on every cycle rddvld is high and has
// no backpressure.
module mctp_spi_mstr_arb
  import mctp_pcievdm_pkg::*;
#(
  parameter int ADDR_WIDTH = 20,
  parameter int BRST_WIDTH = 9,
  parameter int TIMEOUT_US = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pulse_1us,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic                  r0_write,
  input  logic                  r0_read,
  input  logic [BRST_WIDTH-1:0] r0_burstcnt,
  input  logic [31:0]           r0_wrdata,
  output logic [31:0]           r0_rddata,
  output logic                  r0_rddvld,
  output logic                  r0_waitreq,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic                  r1_write,
  input  logic                  r1_read,
  input  logic [BRST_WIDTH-1:0] r1_burstcnt,
  input  logic [31:0]           r1_wrdata,
  output logic [31:0]           r1_rddata,
  output logic                  r1_rddvld,
  output logic                  r1_waitreq,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic                  s_write,
  output logic                  s_read,
  output logic [BRST_WIDTH-1:0] s_burstcnt,
  output logic [31:0]           s_wrdata,
  input  logic [31:0]           s_rddata,
  input  logic                  s_rddvld,
  input  logic                  s_waitreq,
  input  logic                  sts_clr,
  output logic [31:0]           arb_sts,
  output logic [1:0]            dbg_state
);

  localparam int            TW        = $clog2(TIMEOUT_US + 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_US);
  localparam logic [BRST_WIDTH-1:0] ONE_BEAT = BRST_WIDTH'(1);

  function automatic logic [BRST_WIDTH-1:0] norm_burst(input logic [BRST_WIDTH-1:0] b);
    return (b == '0) ? ONE_BEAT : b;
  endfunction

  arb_state_e            state_q, state_d;
  logic [BRST_WIDTH-1:0] beat_q, beat_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  fill_q, fill_d;     // returning timeout fill beats
  logic                  sts_tmo_q, sts_tmo_d;
  logic                  sts_orph_q, sts_orph_d;
  logic [7:0]            tcnt_q, tcnt_d;

  logic [1:0]            req, gnt, gnt_nxt;
  logic                  advance;

  logic [ADDR_WIDTH-1:0] o_addr;
  logic                  o_write, o_read;
  logic [BRST_WIDTH-1:0] o_burst, ld_burst, nxt_burst;
  logic [31:0]           o_wrdata;
  logic                  nxt_write;

  logic                  route_vld, route_fill, orphan_ev, tmo_ev, own_wait;

  assign req     = {r1_write | r1_read, r0_write | r0_read};
  assign advance = (state_q == ARB_IDLE);

  mctp_rr_arb2 u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .advance (advance),
    .gnt     (gnt),
    .gnt_nxt (gnt_nxt)
  );

  // Owner's command signals; only meaningful outside IDLE.
  assign o_addr   = gnt[1] ? r1_addr     : r0_addr;
  assign o_write  = gnt[1] ? r1_write    : r0_write;
  assign o_read   = gnt[1] ? r1_read     : r0_read;
  assign o_burst  = gnt[1] ? r1_burstcnt : r0_burstcnt;
  assign o_wrdata = gnt[1] ? r1_wrdata   : r0_wrdata;
  assign ld_burst = norm_burst(o_burst);

  // Command of whoever wins in IDLE this cycle.
  assign nxt_write = gnt_nxt[1] ? r1_write : r0_write;
  assign nxt_burst = norm_burst(gnt_nxt[1] ? r1_burstcnt : r0_burstcnt);

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    tmo_d      = tmo_q;
    fill_d     = fill_q;
    route_vld  = 1'b0;
    route_fill = 1'b0;
    orphan_ev  = 1'b0;
    tmo_ev     = 1'b0;
    own_wait   = 1'b1;
    s_write    = 1'b0;
    s_read     = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        orphan_ev = s_rddvld;
        if (req != 2'b00) begin
          state_d = nxt_write ? ARB_WR_BURST : ARB_RD_CMD;
          beat_d  = nxt_burst;
        end
      end
      ARB_WR_BURST: begin
        orphan_ev = s_rddvld;
        s_write   = o_write;       // owner may pause; grant is held
        own_wait  = s_waitreq;
        if (o_write && !s_waitreq) begin
          if (beat_q == ONE_BEAT) state_d = ARB_IDLE;
          else                    beat_d  = beat_q - ONE_BEAT;
        end
      end
      ARB_RD_CMD: begin
        s_read   = o_read;
        own_wait = s_waitreq;
        if (o_read && !s_waitreq) begin
          state_d = ARB_RD_WAIT;
          tmo_d   = '0;
          beat_d  = ld_burst;
          // Data arriving with the accept is the first beat.
          if (s_rddvld) begin
            route_vld = 1'b1;
            if (ld_burst == ONE_BEAT) state_d = ARB_IDLE;
            else                      beat_d  = ld_burst - ONE_BEAT;
          end
        end else begin
          orphan_ev = s_rddvld;
        end
      end
      ARB_RD_WAIT: begin
        // The read is already accepted: hold the owner off so a follow-on
        // command is not acknowledged before it can be forwarded.
        if (fill_q) begin
          route_vld  = 1'b1;
          route_fill = 1'b1;
          orphan_ev  = s_rddvld;
          if (beat_q == ONE_BEAT) begin
            state_d = ARB_IDLE;
            fill_d  = 1'b0;
          end else begin
            beat_d = beat_q - ONE_BEAT;
          end
        end else if (s_rddvld) begin
          route_vld = 1'b1;
          tmo_d     = '0;
          if (beat_q == ONE_BEAT) state_d = ARB_IDLE;
          else                    beat_d  = beat_q - ONE_BEAT;
        end else if (tmo_q == TMO_LIMIT) begin
          tmo_ev = 1'b1;
          fill_d = 1'b1;
        end else if (pulse_1us) begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    s_addr     = o_addr;
    s_burstcnt = o_burst;
    s_wrdata   = o_wrdata;
    r0_waitreq = gnt[0] ? own_wait : 1'b1;
    r1_waitreq = gnt[1] ? own_wait : 1'b1;
    r0_rddvld  = route_vld & gnt[0];
    r1_rddvld  = route_vld & gnt[1];
    r0_rddata  = '0;
    r1_rddata  = '0;
    if (r0_rddvld) r0_rddata = route_fill ? ARB_TMO_FILL : s_rddata;
    if (r1_rddvld) r1_rddata = route_fill ? ARB_TMO_FILL : s_rddata;
  end

  // A new event in the same cycle as sts_clr leaves its bit set.
  always_comb begin
    sts_tmo_d  = (sts_tmo_q & ~sts_clr) | tmo_ev;
    sts_orph_d = (sts_orph_q & ~sts_clr) | orphan_ev;
    tcnt_d     = sts_clr ? 8'd0 : tcnt_q;
    if (tmo_ev && (tcnt_d != 8'hFF)) tcnt_d = tcnt_d + 8'd1;
  end

  always_comb begin
    arb_sts                                    = '0;
    arb_sts[ARB_STS_RD_TMO]                    = sts_tmo_q;
    arb_sts[ARB_STS_ORPHAN]                    = sts_orph_q;
    arb_sts[ARB_STS_TCNT_MSB:ARB_STS_TCNT_LSB] = tcnt_q;
  end

  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ARB_IDLE;
      beat_q     <= '0;
      tmo_q      <= '0;
      fill_q     <= 1'b0;
      sts_tmo_q  <= 1'b0;
      sts_orph_q <= 1'b0;
      tcnt_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      tmo_q      <= tmo_d;
      fill_q     <= fill_d;
      sts_tmo_q  <= sts_tmo_d;
      sts_orph_q <= sts_orph_d;
      tcnt_q     <= tcnt_d;
    end
  end

endmodule
